// File: rtl/decode_alu_unit_if.sv
// ============================================================================
// Module      : decode_alu_unit_if
// Description : Bus bundle between instruction memory/register bank and the
//               decode-execute stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface decode_alu_unit_if;
  logic [15:0] instr;
  logic [7:0]  r1;
  logic [7:0]  r2;
  logic [4:0]  alu_op;
  logic [2:0]  addr1;
  logic [2:0]  addr2;
  logic        show;
  logic        write;
  logic [7:0]  res;
  logic        CF;
  logic        ZF;
  logic        SF;
  logic        OF;

  modport master (
    output instr, r1, r2,
    input  alu_op, addr1, addr2, show, write, res, CF, ZF, SF, OF
  );

  modport slave (
    input  instr, r1, r2,
    output alu_op, addr1, addr2, show, write, res, CF, ZF, SF, OF
  );
endinterface

`default_nettype wire

// File: rtl/decode_alu_unit.sv
// ============================================================================
// Module      : decode_alu_unit
// Description : Single-cycle decode + 8-bit ALU with registered CF/ZF/SF/OF.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module decode_alu_unit (
  input  wire logic          clock,
  input  wire logic          reset,
  decode_alu_unit_if.slave   bus
);

  localparam logic [4:0] c_NOP  = 5'h00;
  localparam logic [4:0] c_ADD  = 5'h01;
  localparam logic [4:0] c_SUB  = 5'h02;
  localparam logic [4:0] c_AND  = 5'h03;
  localparam logic [4:0] c_OR   = 5'h04;
  localparam logic [4:0] c_XOR  = 5'h05;
  localparam logic [4:0] c_NOT  = 5'h06;
  localparam logic [4:0] c_SHL  = 5'h07;
  localparam logic [4:0] c_SHR  = 5'h08;
  localparam logic [4:0] c_ADDI = 5'h09;
  localparam logic [4:0] c_SUBI = 5'h0A;
  localparam logic [4:0] c_MOV  = 5'h0B;
  localparam logic [4:0] c_CMP  = 5'h0C;
  localparam logic [4:0] c_SHOW = 5'h0D;
  localparam logic [4:0] c_LDI  = 5'h0E;

  logic [4:0] w_op;
  logic [7:0] w_im;
  logic [7:0] w_opb;
  logic [8:0] w_add;
  logic [8:0] w_sub;
  logic [7:0] w_res;
  logic       w_write;
  logic       w_show;
  logic       w_upd;
  logic       w_cf;
  logic       w_of;
  logic       w_unused_bits;

  logic       r_cf;
  logic       r_zf;
  logic       r_sf;
  logic       r_of;

  assign w_op          = bus.instr[15:11];
  assign w_im          = {5'b0, bus.instr[7:5]};
  assign w_unused_bits = ^bus.instr[4:0];

  // Immediate forms share the adder/subtractor with the register forms.
  assign w_opb = (w_op == c_ADDI || w_op == c_SUBI) ? w_im : bus.r2;
  assign w_add = {1'b0, bus.r1} + {1'b0, w_opb};
  assign w_sub = {1'b0, bus.r1} - {1'b0, w_opb};

  always_comb begin
    w_res   = 8'h00;
    w_write = 1'b0;
    w_show  = 1'b0;
    w_upd   = 1'b0;
    w_cf    = 1'b0;
    w_of    = 1'b0;
    case (w_op)
      c_ADD, c_ADDI: begin
        w_res   = w_add[7:0];
        w_write = 1'b1;
        w_upd   = 1'b1;
        w_cf    = w_add[8];
        w_of    = (bus.r1[7] == w_opb[7]) && (w_add[7] != bus.r1[7]);
      end
      c_SUB, c_SUBI, c_CMP: begin
        w_res   = w_sub[7:0];
        w_write = (w_op != c_CMP);
        w_upd   = 1'b1;
        w_cf    = w_sub[8];
        w_of    = (bus.r1[7] != w_opb[7]) && (w_sub[7] != bus.r1[7]);
      end
      c_AND: begin w_res = bus.r1 & bus.r2; w_write = 1'b1; w_upd = 1'b1; end
      c_OR:  begin w_res = bus.r1 | bus.r2; w_write = 1'b1; w_upd = 1'b1; end
      c_XOR: begin w_res = bus.r1 ^ bus.r2; w_write = 1'b1; w_upd = 1'b1; end
      c_NOT: begin w_res = ~bus.r1;         w_write = 1'b1; w_upd = 1'b1; end
      c_SHL: begin
        w_res   = {bus.r1[6:0], 1'b0};
        w_write = 1'b1;
        w_upd   = 1'b1;
        w_cf    = bus.r1[7];
        w_of    = bus.r1[7] ^ bus.r1[6];
      end
      c_SHR: begin
        w_res   = {1'b0, bus.r1[7:1]};
        w_write = 1'b1;
        w_upd   = 1'b1;
        w_cf    = bus.r1[0];
      end
      c_MOV:  begin w_res = bus.r2; w_write = 1'b1; end
      c_SHOW: begin w_res = bus.r1; w_show  = 1'b1; end
      c_LDI:  begin w_res = w_im;   w_write = 1'b1; end
      c_NOP:  ;
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cf <= 1'b0;
      r_zf <= 1'b0;
      r_sf <= 1'b0;
      r_of <= 1'b0;
    end else if (w_upd) begin
      r_cf <= w_cf;
      r_zf <= (w_res == 8'h00);
      r_sf <= w_res[7];
      r_of <= w_of;
    end
  end

  assign bus.alu_op = w_op;
  assign bus.addr1  = bus.instr[10:8];
  assign bus.addr2  = bus.instr[7:5];
  assign bus.res    = w_res;
  assign bus.write  = w_write;
  assign bus.show   = w_show;
  assign bus.CF     = r_cf;
  assign bus.ZF     = r_zf;
  assign bus.SF     = r_sf;
  assign bus.OF     = r_of;

endmodule

`default_nettype wire

// File: tb/tb_decode_alu_unit.sv
// ============================================================================
// Module      : tb_decode_alu_unit
// Description : Directed vector table plus randomized model check.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_decode_alu_unit;

  logic clock;
  logic reset;
  int   n_cmp;
  int   n_fail;

  decode_alu_unit_if bus ();

  decode_alu_unit dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic [15:0] instr;
    logic [7:0]  r1;
    logic [7:0]  r2;
    logic [7:0]  res;
    logic        wr;
    logic        sh;
    logic [3:0]  fl;   // {CF,ZF,SF,OF} after the edge
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] flags();
    return {bus.CF, bus.ZF, bus.SF, bus.OF};
  endfunction

  // Drive, check combinational outputs, cross one edge, check flags.
  task automatic apply(input string name, input logic [15:0] ins, input logic [7:0] a,
                       input logic [7:0] b, input logic [7:0] e_res, input logic e_wr,
                       input logic e_sh, input logic [3:0] e_fl);
    bus.instr = ins;
    bus.r1    = a;
    bus.r2    = b;
    #1;
    check({name, ".res"},    {24'd0, bus.res}, {24'd0, e_res});
    check({name, ".write"},  {31'd0, bus.write}, {31'd0, e_wr});
    check({name, ".show"},   {31'd0, bus.show},  {31'd0, e_sh});
    check({name, ".fields"}, {21'd0, bus.alu_op, bus.addr1, bus.addr2}, {21'd0, ins[15:5]});
    @(posedge clock);
    #1;
    check({name, ".flags"}, {28'd0, flags()}, {28'd0, e_fl});
  endtask

  function automatic int sx(input logic [7:0] v);
    return (v > 8'd127) ? int'(v) - 256 : int'(v);
  endfunction

  // Reference model expressed as whole-number arithmetic on the operands.
  task automatic model(input logic [15:0] ins, input logic [7:0] a, input logic [7:0] b,
                       output logic [7:0] res, output logic wr, output logic sh,
                       output logic upd, output logic [3:0] fl);
    int op, im, r, s, opb;
    logic cf, of;
    op  = int'(ins[15:11]);
    im  = int'(ins[7:5]);
    res = 8'h00; wr = 1'b0; sh = 1'b0; upd = 1'b0; cf = 1'b0; of = 1'b0;
    r = 0; s = 0;
    opb = (op == 9 || op == 10) ? im : int'(b);
    case (op)
      1, 9: begin
        r = int'(a) + opb; s = sx(a) + sx(8'(opb));
        cf = (r > 255); of = (s > 127) || (s < -128);
        res = 8'(r); wr = 1'b1; upd = 1'b1;
      end
      2, 10, 12: begin
        r = int'(a) - opb; s = sx(a) - sx(8'(opb));
        cf = (r < 0); of = (s > 127) || (s < -128);
        res = 8'(r); wr = (op != 12); upd = 1'b1;
      end
      3: begin res = a & b; wr = 1'b1; upd = 1'b1; end
      4: begin res = a | b; wr = 1'b1; upd = 1'b1; end
      5: begin res = a ^ b; wr = 1'b1; upd = 1'b1; end
      6: begin res = 8'(255 - int'(a)); wr = 1'b1; upd = 1'b1; end
      7: begin
        r = int'(a) * 2; s = sx(a) * 2;
        cf = (r > 255); of = (s > 127) || (s < -128);
        res = 8'(r); wr = 1'b1; upd = 1'b1;
      end
      8: begin
        res = 8'(int'(a) / 2); cf = (int'(a) % 2) == 1;
        wr = 1'b1; upd = 1'b1;
      end
      11: begin res = b; wr = 1'b1; end
      13: begin res = a; sh = 1'b1; end
      14: begin res = 8'(im); wr = 1'b1; end
      default: ;
    endcase
    fl = {cf, (res == 8'h00), res[7], of};
  endtask

  initial begin
    logic [15:0] ins;
    logic [7:0]  a, b, m_res;
    logic        m_wr, m_sh, m_upd;
    logic [3:0]  m_fl, mdl_fl;

    vecs[0]  = '{"add_1_1",    16'h0800, 8'h01, 8'h01, 8'h02, 1'b1, 1'b0, 4'b0000};
    vecs[1]  = '{"add_ovf",    16'h0800, 8'h7F, 8'h01, 8'h80, 1'b1, 1'b0, 4'b0011};
    vecs[2]  = '{"add_carry",  16'h0800, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 4'b1100};
    vecs[3]  = '{"sub_borrow", 16'h1000, 8'h00, 8'h01, 8'hFF, 1'b1, 1'b0, 4'b1010};
    vecs[4]  = '{"cmp_eq",     16'h6000, 8'h05, 8'h05, 8'h00, 1'b0, 1'b0, 4'b0100};
    vecs[5]  = '{"ldi_5",      16'h70A0, 8'h99, 8'h77, 8'h05, 1'b1, 1'b0, 4'b0100};
    vecs[6]  = '{"addi",       16'h4BE0, 8'h10, 8'h33, 8'h17, 1'b1, 1'b0, 4'b0000};
    vecs[7]  = '{"shl",        16'h3800, 8'hC0, 8'h00, 8'h80, 1'b1, 1'b0, 4'b1010};
    vecs[8]  = '{"shr",        16'h4000, 8'h01, 8'h00, 8'h00, 1'b1, 1'b0, 4'b1100};
    vecs[9]  = '{"add_ovf2",   16'h0800, 8'h7F, 8'h01, 8'h80, 1'b1, 1'b0, 4'b0011};
    vecs[10] = '{"show",       16'h6800, 8'hAA, 8'h11, 8'hAA, 1'b0, 1'b1, 4'b0011};
    vecs[11] = '{"op_1f",      16'hF800, 8'h55, 8'h66, 8'h00, 1'b0, 1'b0, 4'b0011};
    vecs[12] = '{"not",        16'h3000, 8'h0F, 8'h00, 8'hF0, 1'b1, 1'b0, 4'b0010};
    vecs[13] = '{"mov",        16'h5800, 8'h01, 8'h3C, 8'h3C, 1'b1, 1'b0, 4'b0010};

    n_cmp = 0; n_fail = 0;
    clock = 1'b0;
    reset = 1'b1;
    bus.instr = 16'h0800; bus.r1 = 8'h7F; bus.r2 = 8'h01;
    #3;
    check("reset_flags", {28'd0, flags()}, 28'd0);
    @(posedge clock);
    #1;
    check("reset_hold_flags", {28'd0, flags()}, 28'd0);
    reset = 1'b0;

    for (int i = 0; i < 14; i++)
      apply(vecs[i].name, vecs[i].instr, vecs[i].r1, vecs[i].r2,
            vecs[i].res, vecs[i].wr, vecs[i].sh, vecs[i].fl);

    // Asynchronous reset mid-cycle, held across an edge, then released.
    apply("pre_reset", 16'h0800, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 4'b1100);
    bus.instr = 16'h0800; bus.r1 = 8'h7F; bus.r2 = 8'h01;
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_flags", {28'd0, flags()}, 28'd0);
    check("reset_res_unaffected", {24'd0, bus.res}, 32'h80);
    @(posedge clock);
    #1;
    check("reset_held_flags", {28'd0, flags()}, 28'd0);
    reset = 1'b0;
    @(posedge clock);
    #1;
    check("post_reset_load", {28'd0, flags()}, 32'b0011);

    mdl_fl = 4'b0011;
    for (int i = 0; i < 400; i++) begin
      ins = 16'($urandom);
      if ($urandom_range(0, 3) != 0) ins[15:11] = 5'($urandom_range(0, 14));
      a = 8'($urandom);
      b = 8'($urandom);
      if ($urandom_range(0, 7) == 0) b = a;
      model(ins, a, b, m_res, m_wr, m_sh, m_upd, m_fl);
      if (m_upd) mdl_fl = m_fl;
      apply("rand", ins, a, b, m_res, m_wr, m_sh, mdl_fl);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
